// File: rtl/iob_sram_ctrl_pkg.sv
// Shared geometry and idle levels for the sky130 OpenRAM 1rw1r 32x512 macro controller.
package iob_sram_ctrl_pkg;

  localparam int SRAM_DATA_W     = 32;
  localparam int SRAM_ADDR_W     = 9;
  localparam int SRAM_NUM_WMASKS = 4;

  // The macro is deselected, reading and mask-free when its port is idle.
  localparam logic SRAM_CSB_IDLE       = 1'b1;
  localparam logic SRAM_WEB_IDLE       = 1'b1;
  localparam logic SRAM_WMASK_IDLE_BIT = 1'b0;

endpackage

// File: rtl/iob_sram_resp_fifo.sv
// Fall-through response FIFO: data pushed into an empty FIFO is visible on the
// output in the same cycle, so a read response costs no extra cycle of latency.
module iob_sram_resp_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              w_empty;
  logic              w_store;
  logic              w_deq;

  // A push into an empty FIFO that is popped in the same cycle bypasses storage entirely.
  always_comb begin
    w_empty = (r_count == '0);
    w_store = i_push & ~(w_empty & i_pop);
    w_deq   = i_pop & ~w_empty;
    o_valid = ~w_empty | i_push;
    o_data  = '0;
    if (!w_empty) begin
      o_data = r_mem[r_rdPtr];
    end else if (i_push) begin
      o_data = i_data;
    end
    o_count = r_count;
  end

  // Storage array carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (w_store) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop at full depth leave the count unchanged.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_store) begin
        r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_deq) begin
        r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
      end
      case ({w_store, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/iob_sram_1rw1r_ctrl.sv
// Two IOb-native slave ports driving the sky130 1rw1r macro: port A (read/write)
// on macro port 0, port B (read-only) on macro port 1, with credit-limited reads,
// per-port in-order response buffering and write/read same-address collision blocking.
module iob_sram_1rw1r_ctrl
  import iob_sram_ctrl_pkg::*;
#(
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int READ_LAT   = 1,
  parameter int RESP_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                a_valid_i,
  input  logic [ADDR_W-1:0]   a_addr_i,
  input  logic [DATA_W-1:0]   a_wdata_i,
  input  logic [DATA_W/8-1:0] a_wstrb_i,
  output logic                a_ready_o,
  output logic                a_rvalid_o,
  output logic [DATA_W-1:0]   a_rdata_o,
  input  logic                a_rready_i,
  input  logic                b_valid_i,
  input  logic [ADDR_W-1:0]   b_addr_i,
  output logic                b_ready_o,
  output logic                b_rvalid_o,
  output logic [DATA_W-1:0]   b_rdata_o,
  input  logic                b_rready_i,
  output logic                sram_csb0_o,
  output logic                sram_web0_o,
  output logic [DATA_W/8-1:0] sram_wmask0_o,
  output logic [ADDR_W-1:0]   sram_addr0_o,
  output logic [DATA_W-1:0]   sram_din0_o,
  input  logic [DATA_W-1:0]   sram_dout0_i,
  output logic                sram_csb1_o,
  output logic [ADDR_W-1:0]   sram_addr1_o,
  input  logic [DATA_W-1:0]   sram_dout1_i
);

  localparam int FIFO_CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int CNT_W      = $clog2(RESP_DEPTH + READ_LAT + 1);

  logic [READ_LAT-1:0]   r_aTrack;
  logic [READ_LAT-1:0]   r_bTrack;
  logic [FIFO_CNT_W-1:0] w_aCount;
  logic [FIFO_CNT_W-1:0] w_bCount;
  logic [CNT_W-1:0]      w_aInflight;
  logic [CNT_W-1:0]      w_bInflight;
  logic                  w_aCredit;
  logic                  w_bCredit;
  logic                  w_aWrite;
  logic                  w_aAcc;
  logic                  w_aRdAcc;
  logic                  w_bAcc;
  logic                  w_collide;
  logic                  w_aCap;
  logic                  w_bCap;

  // Count reads still travelling through the macro pipeline on each port.
  always_comb begin
    w_aInflight = '0;
    w_bInflight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      w_aInflight = w_aInflight + CNT_W'(r_aTrack[i]);
      w_bInflight = w_bInflight + CNT_W'(r_bTrack[i]);
    end
  end

  // Handshakes, credits and collision blocking; nothing is accepted while reset is held.
  always_comb begin
    w_aWrite  = |a_wstrb_i;
    w_aCredit = (w_aInflight + CNT_W'(w_aCount)) < CNT_W'(RESP_DEPTH);
    w_bCredit = (w_bInflight + CNT_W'(w_bCount)) < CNT_W'(RESP_DEPTH);
    a_ready_o = arst_n_i & (w_aWrite | w_aCredit);
    w_aAcc    = a_valid_i & a_ready_o;
    w_aRdAcc  = w_aAcc & ~w_aWrite;
    w_collide = w_aAcc & w_aWrite & b_valid_i & (a_addr_i == b_addr_i);
    b_ready_o = arst_n_i & w_bCredit & ~w_collide;
    w_bAcc    = b_valid_i & b_ready_o;
    w_aCap    = r_aTrack[READ_LAT-1];
    w_bCap    = r_bTrack[READ_LAT-1];
  end

  // Macro control mapping; both ports sit at their idle levels whenever no transfer occurs.
  always_comb begin
    sram_csb0_o   = w_aAcc ? 1'b0 : SRAM_CSB_IDLE;
    sram_web0_o   = w_aAcc ? ~w_aWrite : SRAM_WEB_IDLE;
    sram_wmask0_o = w_aAcc ? a_wstrb_i : {(DATA_W/8){SRAM_WMASK_IDLE_BIT}};
    sram_addr0_o  = a_addr_i;
    sram_din0_o   = a_wdata_i;
    sram_csb1_o   = w_bAcc ? 1'b0 : SRAM_CSB_IDLE;
    sram_addr1_o  = b_addr_i;
  end

  // Read-slot shift registers: the top bit marks the cycle whose macro dout is valid.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_aTrack <= '0;
      r_bTrack <= '0;
    end else begin
      r_aTrack[0] <= w_aRdAcc;
      r_bTrack[0] <= w_bAcc;
      for (int i = 1; i < READ_LAT; i++) begin
        r_aTrack[i] <= r_aTrack[i-1];
        r_bTrack[i] <= r_bTrack[i-1];
      end
    end
  end

  iob_sram_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH),
    .CNT_W  (FIFO_CNT_W)
  ) u_aFifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .i_push   (w_aCap),
    .i_data   (sram_dout0_i),
    .i_pop    (a_rready_i),
    .o_valid  (a_rvalid_o),
    .o_data   (a_rdata_o),
    .o_count  (w_aCount)
  );

  iob_sram_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH),
    .CNT_W  (FIFO_CNT_W)
  ) u_bFifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .i_push   (w_bCap),
    .i_data   (sram_dout1_i),
    .i_pop    (b_rready_i),
    .o_valid  (b_rvalid_o),
    .o_data   (b_rdata_o),
    .o_count  (w_bCount)
  );

endmodule

// File: tb/tb_iob_sram_1rw1r_ctrl.sv
// Directed bench for iob_sram_1rw1r_ctrl with a behavioural 1rw1r macro model.
module tb_iob_sram_1rw1r_ctrl;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic        a_valid_i;
  logic [8:0]  a_addr_i;
  logic [31:0] a_wdata_i;
  logic [3:0]  a_wstrb_i;
  logic        a_ready_o;
  logic        a_rvalid_o;
  logic [31:0] a_rdata_o;
  logic        a_rready_i;
  logic        b_valid_i;
  logic [8:0]  b_addr_i;
  logic        b_ready_o;
  logic        b_rvalid_o;
  logic [31:0] b_rdata_o;
  logic        b_rready_i;
  logic        sram_csb0_o;
  logic        sram_web0_o;
  logic [3:0]  sram_wmask0_o;
  logic [8:0]  sram_addr0_o;
  logic [31:0] sram_din0_o;
  logic [31:0] sram_dout0_i;
  logic        sram_csb1_o;
  logic [8:0]  sram_addr1_o;
  logic [31:0] sram_dout1_i;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] sramMem [512];

  iob_sram_1rw1r_ctrl dut (
    .clk_i         (clk_i),
    .arst_n_i      (arst_n_i),
    .a_valid_i     (a_valid_i),
    .a_addr_i      (a_addr_i),
    .a_wdata_i     (a_wdata_i),
    .a_wstrb_i     (a_wstrb_i),
    .a_ready_o     (a_ready_o),
    .a_rvalid_o    (a_rvalid_o),
    .a_rdata_o     (a_rdata_o),
    .a_rready_i    (a_rready_i),
    .b_valid_i     (b_valid_i),
    .b_addr_i      (b_addr_i),
    .b_ready_o     (b_ready_o),
    .b_rvalid_o    (b_rvalid_o),
    .b_rdata_o     (b_rdata_o),
    .b_rready_i    (b_rready_i),
    .sram_csb0_o   (sram_csb0_o),
    .sram_web0_o   (sram_web0_o),
    .sram_wmask0_o (sram_wmask0_o),
    .sram_addr0_o  (sram_addr0_o),
    .sram_din0_o   (sram_din0_o),
    .sram_dout0_i  (sram_dout0_i),
    .sram_csb1_o   (sram_csb1_o),
    .sram_addr1_o  (sram_addr1_o),
    .sram_dout1_i  (sram_dout1_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] initWord(input int idx);
    return 32'hC0DE0000 | 32'(idx);
  endfunction

  // Macro model: one-cycle read latency, byte-masked writes, dout undefined when not reading.
  always @(posedge clk_i) begin
    if (!sram_csb0_o) begin
      if (!sram_web0_o) begin
        for (int i = 0; i < 4; i++) begin
          if (sram_wmask0_o[i]) sramMem[sram_addr0_o][8*i +: 8] <= sram_din0_o[8*i +: 8];
        end
        sram_dout0_i <= 'x;
      end else begin
        sram_dout0_i <= sramMem[sram_addr0_o];
      end
    end else begin
      sram_dout0_i <= 'x;
    end
    if (!sram_csb1_o) begin
      if (!sram_csb0_o && !sram_web0_o && (sram_addr0_o == sram_addr1_o)) sram_dout1_i <= 'x;
      else sram_dout1_i <= sramMem[sram_addr1_o];
    end else begin
      sram_dout1_i <= 'x;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic aValid, input logic [8:0] aAddr, input logic [31:0] aWdata,
                               input logic [3:0] aWstrb, input logic bValid, input logic [8:0] bAddr);
    a_valid_i = aValid;
    a_addr_i  = aAddr;
    a_wdata_i = aWdata;
    a_wstrb_i = aWstrb;
    b_valid_i = bValid;
    b_addr_i  = bAddr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int nextReq;
    int nextResp;
    for (int i = 0; i < 512; i++) sramMem[i] = initWord(i);
    arst_n_i   = 1'b0;
    a_rready_i = 1'b1;
    b_rready_i = 1'b1;
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 9'h0);

    // Reset state, before any clock edge and after several edges
    checkOutput("rst_csb0", 32'(sram_csb0_o), 32'd1);
    checkOutput("rst_csb1", 32'(sram_csb1_o), 32'd1);
    checkOutput("rst_web0", 32'(sram_web0_o), 32'd1);
    checkOutput("rst_wmask0", 32'(sram_wmask0_o), 32'd0);
    checkOutput("rst_a_rvalid", 32'(a_rvalid_o), 32'd0);
    checkOutput("rst_b_rvalid", 32'(b_rvalid_o), 32'd0);
    tick();
    tick();
    checkOutput("rst_clk_csb0", 32'(sram_csb0_o), 32'd1);
    checkOutput("rst_clk_a_rdata", a_rdata_o, 32'd0);
    checkOutput("rst_clk_b_rdata", b_rdata_o, 32'd0);
    arst_n_i = 1'b1;

    // Full write then read-back on port A
    applyStimulus(1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 1'b0, 9'h0);
    checkOutput("wr_ready", 32'(a_ready_o), 32'd1);
    checkOutput("wr_csb0", 32'(sram_csb0_o), 32'd0);
    checkOutput("wr_web0", 32'(sram_web0_o), 32'd0);
    checkOutput("wr_wmask0", 32'(sram_wmask0_o), 32'hF);
    checkOutput("wr_addr0", 32'(sram_addr0_o), 32'h010);
    tick();
    applyStimulus(1'b1, 9'h010, 32'h0, 4'h0, 1'b0, 9'h0);
    checkOutput("rd_ready", 32'(a_ready_o), 32'd1);
    checkOutput("rd_web0", 32'(sram_web0_o), 32'd1);
    checkOutput("wr_no_rvalid", 32'(a_rvalid_o), 32'd0);
    tick();
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 9'h0);
    checkOutput("rd_rvalid", 32'(a_rvalid_o), 32'd1);
    checkOutput("rd_rdata", a_rdata_o, 32'hDEADBEEF);
    tick();
    checkOutput("rd_rvalid_drop", 32'(a_rvalid_o), 32'd0);

    // Partial byte write then read-back
    applyStimulus(1'b1, 9'h010, 32'h0000AA00, 4'h2, 1'b0, 9'h0);
    checkOutput("pwr_wmask0", 32'(sram_wmask0_o), 32'h2);
    tick();
    applyStimulus(1'b1, 9'h010, 32'h0, 4'h0, 1'b0, 9'h0);
    tick();
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 9'h0);
    checkOutput("prd_rvalid", 32'(a_rvalid_o), 32'd1);
    checkOutput("prd_rdata", a_rdata_o, 32'hDEADAAEF);
    tick();

    // Port B streaming under backpressure: credits run out after two acceptances
    b_rready_i = 1'b0;
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'd0);
    checkOutput("bp_ready0", 32'(b_ready_o), 32'd1);
    tick();
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'd1);
    checkOutput("bp_ready1", 32'(b_ready_o), 32'd1);
    checkOutput("bp_first_rvalid", 32'(b_rvalid_o), 32'd1);
    tick();
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'd2);
    checkOutput("bp_ready2_stall", 32'(b_ready_o), 32'd0);
    tick();
    tick();
    checkOutput("bp_ready_hold", 32'(b_ready_o), 32'd0);
    checkOutput("bp_rvalid_hold", 32'(b_rvalid_o), 32'd1);
    checkOutput("bp_rdata_hold", b_rdata_o, initWord(0));
    b_rready_i = 1'b1;
    nextReq  = 2;
    nextResp = 0;
    for (int cyc = 0; cyc < 40 && nextResp < 8; cyc++) begin
      applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, nextReq < 8, 9'(nextReq));
      if (b_rvalid_o) begin
        checkOutput("bp_order", b_rdata_o, initWord(nextResp));
        nextResp++;
      end
      if (b_valid_i && b_ready_o) nextReq++;
      tick();
    end
    checkOutput("bp_resp_count", 32'(nextResp), 32'd8);
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 9'h0);
    checkOutput("bp_no_extra", 32'(b_rvalid_o), 32'd0);
    tick();
    checkOutput("bp_no_extra2", 32'(b_rvalid_o), 32'd0);

    // Same-address A write and B read: B is held one cycle and returns the new data
    applyStimulus(1'b1, 9'h1FF, 32'h12345678, 4'hF, 1'b1, 9'h1FF);
    checkOutput("col_a_ready", 32'(a_ready_o), 32'd1);
    checkOutput("col_b_ready", 32'(b_ready_o), 32'd0);
    checkOutput("col_csb1", 32'(sram_csb1_o), 32'd1);
    tick();
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h1FF);
    checkOutput("col_b_ready_next", 32'(b_ready_o), 32'd1);
    checkOutput("col_csb1_next", 32'(sram_csb1_o), 32'd0);
    checkOutput("col_addr1", 32'(sram_addr1_o), 32'h1FF);
    tick();
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 9'h0);
    checkOutput("col_b_rvalid", 32'(b_rvalid_o), 32'd1);
    checkOutput("col_b_rdata", b_rdata_o, 32'h12345678);
    tick();

    // Back-to-back A reads across the address wrap with no bubbles
    applyStimulus(1'b1, 9'h1FF, 32'h0, 4'h0, 1'b0, 9'h0);
    checkOutput("wrap_ready0", 32'(a_ready_o), 32'd1);
    checkOutput("wrap_addr0_hi", 32'(sram_addr0_o), 32'h1FF);
    tick();
    applyStimulus(1'b1, 9'h000, 32'h0, 4'h0, 1'b0, 9'h0);
    checkOutput("wrap_ready1", 32'(a_ready_o), 32'd1);
    checkOutput("wrap_csb0", 32'(sram_csb0_o), 32'd0);
    checkOutput("wrap_addr0_lo", 32'(sram_addr0_o), 32'h000);
    checkOutput("wrap_rdata_hi", a_rdata_o, 32'h12345678);
    tick();
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 9'h0);
    checkOutput("wrap_rvalid_lo", 32'(a_rvalid_o), 32'd1);
    checkOutput("wrap_rdata_lo", a_rdata_o, initWord(0));
    tick();
    checkOutput("wrap_rvalid_end", 32'(a_rvalid_o), 32'd0);

    // Reset while two B reads are outstanding discards them
    b_rready_i = 1'b0;
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'd5);
    tick();
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'd6);
    checkOutput("mid_ready6", 32'(b_ready_o), 32'd1);
    tick();
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 9'h0);
    checkOutput("mid_pending", 32'(b_rvalid_o), 32'd1);
    arst_n_i = 1'b0;
    #1;
    checkOutput("mid_rst_rvalid", 32'(b_rvalid_o), 32'd0);
    checkOutput("mid_rst_rdata", b_rdata_o, 32'd0);
    tick();
    tick();
    arst_n_i   = 1'b1;
    b_rready_i = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      checkOutput("mid_no_rvalid", 32'(b_rvalid_o), 32'd0);
      tick();
    end
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'd7);
    checkOutput("mid_after_ready", 32'(b_ready_o), 32'd1);
    tick();
    applyStimulus(1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 9'h0);
    checkOutput("mid_after_rvalid", 32'(b_rvalid_o), 32'd1);
    checkOutput("mid_after_rdata", b_rdata_o, initWord(7));
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
